// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding, datapath select encodings and per-state control decode
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  // An unsupported opcode raises a sticky flag and silently resumes fetching.
  localparam logic   ILLEGAL_STICKY = 1'b1;
  localparam state_e ILLEGAL_RESUME = S_FETCH;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_source;
  } ctrl_t;

  function automatic ctrl_t ctrl_for_state(input state_e s, input logic [5:0] op);
    ctrl_t c;
    c.iord       = 1'b0;
    c.mem_read   = 1'b0;
    c.mem_write  = 1'b0;
    c.reg_dst    = 1'b0;
    c.mem_to_reg = 1'b0;
    c.reg_write  = 1'b0;
    c.alu_src_a  = 1'b0;
    c.alu_src_b  = SRCB_REG;
    c.alu_op     = ALU_ADD;
    c.pc_source  = PC_ALU;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_source = PC_ALUOUT;
      end
      S_JUMP:     c.pc_source = PC_JUMP;
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ORI:  c.alu_op = ALU_OR;
          OP_ANDI: c.alu_op = ALU_AND;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB:     c.reg_write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_perf_counters.sv
// rtl/mips_perf_counters.sv - free-running cycle and retired-instruction counters, wrap at 2^32
module mips_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_done,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    instr_d = instr_done ? instr_q + 32'd1 : instr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM; MULTICYCLE_PERF_CNT_EN adds perf counters
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        IllegalOp,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:                 state_d = S_R_EXEC;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_ADDI, OP_ORI, OP_ANDI: state_d = S_I_EXEC;
          default: begin
            state_d   = ILLEGAL_RESUME;
            illegal_d = ILLEGAL_STICKY;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
      S_MEM_WR:   if (MemReady) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
    // Moore outputs are decoded from the next state so they leave a flop.
    ctrl_d = ctrl_for_state(state_d, Opcode);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      ctrl_q    <= ctrl_for_state(S_FETCH, OP_RTYPE);
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  logic branch_taken;
  assign branch_taken = (Opcode == OP_BNE) ? ~Zero : Zero;

  // Write strobes are gated by reset so an abandoned instruction cannot commit.
  assign PCWrite  = ~reset & (((state_q == S_FETCH) & MemReady) | (state_q == S_JUMP) |
                              ((state_q == S_BRANCH) & branch_taken));
  assign IRWrite  = ~reset & (state_q == S_FETCH) & MemReady;
  assign RegWrite = ~reset & ctrl_q.reg_write;
  assign MemWrite = ~reset & ctrl_q.mem_write;

  assign IorD      = ctrl_q.iord;
  assign MemRead   = ctrl_q.mem_read;
  assign RegDst    = ctrl_q.reg_dst;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign PCSource  = ctrl_q.pc_source;
  assign State     = state_q;
  assign IllegalOp = illegal_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic instr_done;
  assign instr_done = ~reset & (state_d == S_FETCH) &
                      ((state_q == S_MEM_WB) | (state_q == S_MEM_WR) | (state_q == S_R_WB) |
                       (state_q == S_BRANCH) | (state_q == S_JUMP)   | (state_q == S_I_WB));

  mips_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .instr_done  (instr_done),
    .cycle_count (CycleCount),
    .instr_count (InstrCount)
  );
`else
  assign CycleCount = 32'd0;
  assign InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed per-cycle vectors for the multi-cycle control FSM
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = 6'd0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  State;
  logic        IllegalOp;
  logic [31:0] CycleCount, InstrCount;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .IllegalOp(IllegalOp), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, ANDI = 6'b001100, BAD = 6'b111111;

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  localparam logic [15:0] V_F1     = 16'b1_0_1_0_1_0_0_0_0_01_000_00;
  localparam logic [15:0] V_F0     = 16'b0_0_1_0_0_0_0_0_0_01_000_00;
  localparam logic [15:0] V_DEC    = 16'b0_0_0_0_0_0_0_0_0_11_000_00;
  localparam logic [15:0] V_MADDR  = 16'b0_0_0_0_0_0_0_0_1_10_000_00;
  localparam logic [15:0] V_MRD    = 16'b0_1_1_0_0_0_0_0_0_00_000_00;
  localparam logic [15:0] V_MWB    = 16'b0_0_0_0_0_0_1_1_0_00_000_00;
  localparam logic [15:0] V_MWR    = 16'b0_1_0_1_0_0_0_0_0_00_000_00;
  localparam logic [15:0] V_MWR_RS = 16'b0_1_0_0_0_0_0_0_0_00_000_00;
  localparam logic [15:0] V_REX    = 16'b0_0_0_0_0_0_0_0_1_00_010_00;
  localparam logic [15:0] V_RWB    = 16'b0_0_0_0_0_1_0_1_0_00_000_00;
  localparam logic [15:0] V_BR_T   = 16'b1_0_0_0_0_0_0_0_1_00_001_01;
  localparam logic [15:0] V_BR_N   = 16'b0_0_0_0_0_0_0_0_1_00_001_01;
  localparam logic [15:0] V_JMP    = 16'b1_0_0_0_0_0_0_0_0_00_000_10;
  localparam logic [15:0] V_IEX_AD = 16'b0_0_0_0_0_0_0_0_1_10_000_00;
  localparam logic [15:0] V_IEX_OR = 16'b0_0_0_0_0_0_0_0_1_10_011_00;
  localparam logic [15:0] V_IEX_AN = 16'b0_0_0_0_0_0_0_0_1_10_100_00;
  localparam logic [15:0] V_IWB    = 16'b0_0_0_0_0_0_0_1_0_00_000_00;

  logic [15:0] out_vec;
  assign out_vec = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_cyc = 32'd0;
  logic [31:0] exp_instr = 32'd0;
  logic        exp_ill = 1'b0;

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef MULTICYCLE_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, compare everything mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [15:0] vec);
    Opcode   = op;
    MemReady = rdy;
    Zero     = z;
    @(negedge clk);
    chk({tag, ".state"}, {28'd0, State}, {28'd0, st});
    chk({tag, ".ctl"}, {16'd0, out_vec}, {16'd0, vec});
    chk({tag, ".ill"}, {31'd0, IllegalOp}, {31'd0, exp_ill});
    chk({tag, ".cyc"}, CycleCount, perf(exp_cyc));
    chk({tag, ".ins"}, InstrCount, perf(exp_instr));
    @(posedge clk);
    exp_cyc = reset ? 32'd0 : exp_cyc + 32'd1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst", RT, 1, 0, 4'd0, V_F0);
    reset = 1'b0;

    cyc("r.f", RT, 1, 0, 4'd0, V_F1);
    cyc("r.d", RT, 1, 0, 4'd1, V_DEC);
    cyc("r.x", RT, 1, 0, 4'd6, V_REX);
    cyc("r.wb", RT, 1, 0, 4'd7, V_RWB);
    exp_instr++;

    cyc("lw.f", LW, 1, 0, 4'd0, V_F1);
    cyc("lw.d", LW, 1, 0, 4'd1, V_DEC);
    cyc("lw.a", LW, 1, 0, 4'd2, V_MADDR);
    for (int i = 0; i < 3; i++) cyc("lw.wait", LW, 0, 0, 4'd3, V_MRD);
    cyc("lw.rd", LW, 1, 0, 4'd3, V_MRD);
    cyc("lw.wb", LW, 1, 0, 4'd4, V_MWB);
    exp_instr++;

    cyc("sw.f", SW, 1, 0, 4'd0, V_F1);
    cyc("sw.d", SW, 1, 0, 4'd1, V_DEC);
    cyc("sw.a", SW, 1, 0, 4'd2, V_MADDR);
    cyc("sw.w", SW, 1, 0, 4'd5, V_MWR);
    exp_instr++;

    cyc("bne1.f", BNE, 1, 1, 4'd0, V_F1);
    cyc("bne1.d", BNE, 1, 1, 4'd1, V_DEC);
    cyc("bne1.b", BNE, 1, 1, 4'd8, V_BR_N);
    exp_instr++;
    cyc("bne0.f", BNE, 1, 0, 4'd0, V_F1);
    cyc("bne0.d", BNE, 1, 0, 4'd1, V_DEC);
    cyc("bne0.b", BNE, 1, 0, 4'd8, V_BR_T);
    exp_instr++;
    cyc("beq1.f", BEQ, 1, 1, 4'd0, V_F1);
    cyc("beq1.d", BEQ, 1, 1, 4'd1, V_DEC);
    cyc("beq1.b", BEQ, 1, 1, 4'd8, V_BR_T);
    exp_instr++;

    cyc("j.f", JMP, 1, 0, 4'd0, V_F1);
    cyc("j.d", JMP, 1, 0, 4'd1, V_DEC);
    cyc("j.j", JMP, 1, 0, 4'd9, V_JMP);
    exp_instr++;

    cyc("ori.f", ORI, 1, 0, 4'd0, V_F1);
    cyc("ori.d", ORI, 1, 0, 4'd1, V_DEC);
    cyc("ori.x", ORI, 1, 0, 4'd10, V_IEX_OR);
    cyc("ori.wb", ORI, 1, 0, 4'd11, V_IWB);
    exp_instr++;
    cyc("andi.f", ANDI, 1, 0, 4'd0, V_F1);
    cyc("andi.d", ANDI, 1, 0, 4'd1, V_DEC);
    cyc("andi.x", ANDI, 1, 0, 4'd10, V_IEX_AN);
    cyc("andi.wb", ANDI, 1, 0, 4'd11, V_IWB);
    exp_instr++;
    cyc("addi.f", ADDI, 1, 0, 4'd0, V_F1);
    cyc("addi.d", ADDI, 1, 0, 4'd1, V_DEC);
    cyc("addi.x", ADDI, 1, 0, 4'd10, V_IEX_AD);
    cyc("addi.wb", ADDI, 1, 0, 4'd11, V_IWB);
    exp_instr++;

    cyc("bad.f", BAD, 1, 0, 4'd0, V_F1);
    cyc("bad.d", BAD, 1, 0, 4'd1, V_DEC);
    exp_ill = 1'b1;

    cyc("fw.wait", JMP, 0, 0, 4'd0, V_F0);
    cyc("fw.f", JMP, 1, 0, 4'd0, V_F1);
    cyc("fw.d", JMP, 1, 0, 4'd1, V_DEC);
    cyc("fw.j", JMP, 1, 0, 4'd9, V_JMP);
    exp_instr++;

    cyc("rsw.f", SW, 1, 0, 4'd0, V_F1);
    cyc("rsw.d", SW, 1, 0, 4'd1, V_DEC);
    cyc("rsw.a", SW, 1, 0, 4'd2, V_MADDR);
    reset = 1'b1;
    cyc("rsw.w", SW, 1, 0, 4'd5, V_MWR_RS);
    reset = 1'b0;
    exp_instr = 32'd0;
    exp_ill   = 1'b0;
    cyc("rsw.after", SW, 0, 0, 4'd0, V_F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
